// File: rtl/sweep_scheduler.sv
// sweep_scheduler: steps the beam angle through a sweep and sequences settle, burst, listen and report per angle.
// Optional macro SWEEP_BIDIR_EN selects a ping-pong sweep; the default build is a sawtooth sweep.
module sweep_scheduler #(
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int BURST_CYCLES  = 524288,
    parameter int LISTEN_CYCLES = 16252928,
    parameter int RANGE_WIDTH   = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_start_out,
    output logic                          tx_active_out,
    output logic                          listen_active_out,
    input  logic                          echo_valid_in,
    input  logic [RANGE_WIDTH-1:0]        echo_range_in,
    output logic                          rpt_valid_out,
    input  logic                          rpt_ready_in,
    output logic [ANGLE_WIDTH-1:0]        rpt_angle_out,
    output logic [RANGE_WIDTH-1:0]        rpt_range_out,
    output logic                          rpt_hit_out,
    output logic                          sweep_done_out,
    output logic                          busy_out
);

    localparam int MAX_SB  = (SETTLE_CYCLES > BURST_CYCLES) ? SETTLE_CYCLES : BURST_CYCLES;
    localparam int MAX_CYC = (MAX_SB > LISTEN_CYCLES) ? MAX_SB : LISTEN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);

    // Angle arithmetic runs one bit wider so the step can never wrap the sign.
    localparam logic signed [ANGLE_WIDTH:0]   A_MAX_X  = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   A_STEP_X = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH-1:0] A_MIN    = ANGLE_WIDTH'(ANGLE_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_BURST,
        S_LISTEN,
        S_REPORT,
        S_ADVANCE
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic signed [ANGLE_WIDTH-1:0]   r_angle;
    logic signed [ANGLE_WIDTH-1:0]   r_rpt_angle;
    logic [RANGE_WIDTH-1:0]          r_rpt_range;
    logic                            r_rpt_hit;
    logic signed [ANGLE_WIDTH:0]     w_up;
    logic                            w_top;
    logic                            w_last;
    logic signed [ANGLE_WIDTH-1:0]   w_angle_nxt;

    assign w_up  = $signed({r_angle[ANGLE_WIDTH-1], r_angle}) + A_STEP_X;
    assign w_top = (w_up > A_MAX_X);

`ifdef SWEEP_BIDIR_EN
    localparam logic signed [ANGLE_WIDTH:0] A_MIN_X = (ANGLE_WIDTH+1)'(ANGLE_MIN);

    logic                        r_dir_up;
    logic signed [ANGLE_WIDTH:0] w_dn;
    logic                        w_bot;

    assign w_dn  = $signed({r_angle[ANGLE_WIDTH-1], r_angle}) - A_STEP_X;
    assign w_bot = (w_dn < A_MIN_X);

    // Endpoint angles are visited once per turn; a single-angle sweep just holds.
    always_comb begin
        w_last      = r_dir_up ? w_top : w_bot;
        w_angle_nxt = r_angle;
        if (r_dir_up) begin
            if (!w_top)
                w_angle_nxt = $signed(w_up[ANGLE_WIDTH-1:0]);
            else if (!w_bot)
                w_angle_nxt = $signed(w_dn[ANGLE_WIDTH-1:0]);
        end else begin
            if (!w_bot)
                w_angle_nxt = $signed(w_dn[ANGLE_WIDTH-1:0]);
            else if (!w_top)
                w_angle_nxt = $signed(w_up[ANGLE_WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_dir_up <= 1'b1;
        else if (r_state == S_ADVANCE && w_last)
            r_dir_up <= ~r_dir_up;
    end
`else
    always_comb begin
        w_last      = w_top;
        w_angle_nxt = w_top ? A_MIN : $signed(w_up[ANGLE_WIDTH-1:0]);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable_in) w_state_nxt = S_SETTLE;
            S_SETTLE:  if (r_cnt == SETTLE_LAST) w_state_nxt = S_BURST;
            S_BURST:   if (r_cnt == BURST_LAST) w_state_nxt = S_LISTEN;
            S_LISTEN:  if (echo_valid_in || r_cnt == LISTEN_LAST) w_state_nxt = S_REPORT;
            S_REPORT:  if (rpt_ready_in) w_state_nxt = S_ADVANCE;
            S_ADVANCE: w_state_nxt = enable_in ? S_SETTLE : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_angle     <= A_MIN;
            r_rpt_angle <= '0;
            r_rpt_range <= '0;
            r_rpt_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == S_SETTLE || r_state == S_BURST || r_state == S_LISTEN)
                r_cnt <= r_cnt + 1'b1;
            // An echo in the final listen cycle takes priority over the timeout.
            if (r_state == S_LISTEN && w_state_nxt == S_REPORT) begin
                r_rpt_angle <= r_angle;
                r_rpt_range <= echo_valid_in ? echo_range_in : '0;
                r_rpt_hit   <= echo_valid_in;
            end
            if (r_state == S_ADVANCE)
                r_angle <= w_angle_nxt;
        end
    end

    assign beam_angle_out    = r_angle;
    assign burst_start_out   = (r_state == S_BURST) && (r_cnt == '0);
    assign tx_active_out     = (r_state == S_BURST);
    assign listen_active_out = (r_state == S_LISTEN);
    assign rpt_valid_out     = (r_state == S_REPORT);
    assign rpt_angle_out     = r_rpt_angle;
    assign rpt_range_out     = r_rpt_range;
    assign rpt_hit_out       = r_rpt_hit;
    assign sweep_done_out    = (r_state == S_ADVANCE) && w_last;
    assign busy_out          = (r_state != S_IDLE);

endmodule

// File: tb/tb_sweep_scheduler.sv
// Self-checking bench for sweep_scheduler: timeline-based reference model plus directed and random scenarios.
// Honours SWEEP_BIDIR_EN so the same bench covers both sweep styles.
module tb_sweep_scheduler;

    localparam int AW    = 8;
    localparam int RW    = 16;
    localparam int S     = 2;
    localparam int B     = 4;
    localparam int L     = 20;
    localparam int AMIN  = -30;
    localparam int AMAX  = 30;
    localparam int ASTEP = 10;
    localparam int NANG  = (AMAX - AMIN) / ASTEP + 1;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 enable_in = 1'b0;
    logic                 echo_valid_in = 1'b0;
    logic [RW-1:0]        echo_range_in = '0;
    logic                 rpt_ready_in = 1'b1;
    logic signed [AW-1:0] beam_angle_out;
    logic                 burst_start_out, tx_active_out, listen_active_out;
    logic                 rpt_valid_out, rpt_hit_out, sweep_done_out, busy_out;
    logic [AW-1:0]        rpt_angle_out;
    logic [RW-1:0]        rpt_range_out;

    sweep_scheduler #(
        .ANGLE_WIDTH(AW), .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX), .ANGLE_STEP(ASTEP),
        .SETTLE_CYCLES(S), .BURST_CYCLES(B), .LISTEN_CYCLES(L), .RANGE_WIDTH(RW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .beam_angle_out(beam_angle_out), .burst_start_out(burst_start_out),
        .tx_active_out(tx_active_out), .listen_active_out(listen_active_out),
        .echo_valid_in(echo_valid_in), .echo_range_in(echo_range_in),
        .rpt_valid_out(rpt_valid_out), .rpt_ready_in(rpt_ready_in),
        .rpt_angle_out(rpt_angle_out), .rpt_range_out(rpt_range_out),
        .rpt_hit_out(rpt_hit_out), .sweep_done_out(sweep_done_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
        end
    endtask

    function automatic int ang(input int idx);
        return AMIN + idx * ASTEP;
    endfunction

    function automatic bit endpoint(input int idx, input bit up);
`ifdef SWEEP_BIDIR_EN
        return up ? (idx == NANG - 1) : (idx == 0);
`else
        return idx == NANG - 1;
`endif
    endfunction

    // Reference model: each ping is a timeline anchored at its first settle cycle.
    bit            m_ok = 1'b0, m_busy = 1'b0, m_up = 1'b1, m_hit = 1'b0;
    int            m_idx = 0, m_ps = 0, m_rs = -1, m_adv = -1, m_acc = 0, m_rang = 0;
    logic [RW-1:0] m_rng = '0;

    always @(negedge clk_in) begin : model
        int c, ls;
        bit e_bs, e_tx, e_ls, e_rv, e_adv, e_done;
        c      = cyc;
        ls     = m_ps + S + B;
        e_bs   = m_busy && (c == m_ps + S);
        e_tx   = m_busy && (c >= m_ps + S) && (c < ls);
        e_ls   = m_busy && (c >= ls) && (m_rs < 0);
        e_rv   = m_busy && (m_rs >= 0) && (c >= m_rs) && (m_adv < 0);
        e_adv  = m_busy && (m_adv >= 0) && (c == m_adv);
        e_done = e_adv && endpoint(m_idx, m_up);
        if (m_ok) begin
            chk("beam_angle", $signed(beam_angle_out), ang(m_idx));
            chk("burst_start", burst_start_out, e_bs);
            chk("tx_active", tx_active_out, e_tx);
            chk("listen_active", listen_active_out, e_ls);
            chk("rpt_valid", rpt_valid_out, e_rv);
            chk("sweep_done", sweep_done_out, e_done);
            chk("busy", busy_out, m_busy);
            if (e_rv) begin
                chk("rpt_angle", $signed(rpt_angle_out), m_rang);
                chk("rpt_range", rpt_range_out, m_rng);
                chk("rpt_hit", rpt_hit_out, m_hit);
            end
        end
        if (rst_in) begin
            m_ok = 1'b1; m_busy = 1'b0; m_idx = 0; m_up = 1'b1; m_rs = -1; m_adv = -1;
        end else if (!m_busy) begin
            if (enable_in) begin
                m_busy = 1'b1; m_ps = c + 1; m_rs = -1; m_adv = -1;
            end
        end else if (e_ls) begin
            if (echo_valid_in) begin
                m_rs = c + 1; m_hit = 1'b1; m_rng = echo_range_in; m_rang = ang(m_idx);
            end else if (c == ls + L - 1) begin
                m_rs = c + 1; m_hit = 1'b0; m_rng = '0; m_rang = ang(m_idx);
            end
        end else if (e_rv && rpt_ready_in) begin
            m_adv = c + 1;
            m_acc++;
        end else if (e_adv) begin
            if (endpoint(m_idx, m_up)) begin
`ifdef SWEEP_BIDIR_EN
                m_up  = ~m_up;
                m_idx = m_up ? m_idx + 1 : m_idx - 1;
`else
                m_idx = 0;
`endif
            end else begin
                m_idx = m_up ? m_idx + 1 : m_idx - 1;
            end
            if (enable_in) begin
                m_ps = c + 1; m_rs = -1; m_adv = -1;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    // One cycle: drive inputs just after the edge, then observe at the falling edge.
    task automatic go(input bit r, input bit en, input bit ev, input logic [RW-1:0] rng, input bit rdy);
        @(posedge clk_in);
        #2;
        rst_in = r; enable_in = en; echo_valid_in = ev; echo_range_in = rng; rpt_ready_in = rdy;
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        go(1, 0, 0, '0, 1);
        go(1, 0, 0, '0, 1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_tx"}, tx_active_out, 0);
        chk({tag, "_listen"}, listen_active_out, 0);
        chk({tag, "_bstart"}, burst_start_out, 0);
        chk({tag, "_valid"}, rpt_valid_out, 0);
        chk({tag, "_done"}, sweep_done_out, 0);
        chk({tag, "_hit"}, rpt_hit_out, 0);
        chk({tag, "_range"}, rpt_range_out, 0);
        chk({tag, "_rangle"}, rpt_angle_out, 0);
        chk({tag, "_beam"}, $signed(beam_angle_out), -30);
    endtask

    initial begin
        int t_en, t_bs, ntx, nls, nacc, ndone, done_at;
        bit found;
        int acc_ang[16];
        bit en_s;

        // Scenario 1: reset state, then one ping with no echo.
        do_reset();
        chk_idle_zero("reset");
        go(0, 1, 0, '0, 1);
        t_en = cyc; found = 0; t_bs = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            go(0, 1, 0, '0, 1);
            if (burst_start_out) begin found = 1; t_bs = cyc; end
        end
        chk("s1_burst_seen", found, 1);
        chk("s1_burst_latency", t_bs - t_en, 3);
        ntx = 1; nls = 0; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            go(0, 1, 0, '0, 1);
            if (tx_active_out) ntx++;
            if (listen_active_out) nls++;
            if (rpt_valid_out) found = 1;
        end
        chk("s1_report_seen", found, 1);
        chk("s1_tx_cycles", ntx, 4);
        chk("s1_listen_cycles", nls, 20);
        chk("s1_rpt_angle", $signed(rpt_angle_out), -30);
        chk("s1_rpt_range", rpt_range_out, 0);
        chk("s1_rpt_hit", rpt_hit_out, 0);

        // Scenario 2: echo in listen cycle 5, second echo ignored.
        do_reset();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            go(0, 1, 0, '0, 1);
            if (listen_active_out) found = 1;
        end
        chk("s2_listen_seen", found, 1);
        for (int i = 1; i < 5; i++) go(0, 1, 0, '0, 1);
        go(0, 1, 1, 16'h0123, 1);
        chk("s2_listen5", listen_active_out, 1);
        go(0, 1, 1, 16'h0BEE, 1);
        chk("s2_valid", rpt_valid_out, 1);
        chk("s2_angle", $signed(rpt_angle_out), -30);
        chk("s2_range", rpt_range_out, 16'h0123);
        chk("s2_hit", rpt_hit_out, 1);
        go(0, 1, 0, '0, 1);
        chk("s2_adv_valid", rpt_valid_out, 0);
        go(0, 1, 0, '0, 1);
        chk("s2_beam_next", $signed(beam_angle_out), -20);

        // Scenario 3: ten cycles of backpressure on the -20 record.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            go(0, 1, 0, '0, 0);
            if (rpt_valid_out) found = 1;
        end
        chk("s3_report_seen", found, 1);
        for (int i = 1; i < 10; i++) begin
            go(0, 1, 0, '0, 0);
            chk("s3_stall_valid", rpt_valid_out, 1);
            chk("s3_stall_angle", $signed(rpt_angle_out), -20);
            chk("s3_stall_hit", rpt_hit_out, 0);
        end
        go(0, 1, 0, '0, 1);
        chk("s3_accept_valid", rpt_valid_out, 1);
        go(0, 1, 0, '0, 1);
        chk("s3_after_valid", rpt_valid_out, 0);

        // Scenario 4: full sweep with ready held high and random echoes.
        do_reset();
        nacc = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 3000 && nacc < NANG; i++) begin
            go(0, 1, ($urandom_range(0, 15) == 0), RW'($urandom), 1);
            if (sweep_done_out) begin ndone++; done_at = nacc; end
            if (rpt_valid_out) begin acc_ang[nacc] = $signed(rpt_angle_out); nacc++; end
        end
        chk("s4_records", nacc, NANG);
        go(0, 1, 0, '0, 1);
        if (sweep_done_out) begin ndone++; done_at = nacc; end
        for (int k = 0; k < NANG; k++) chk("s4_record_angle", acc_ang[k], ang(k));
        chk("s4_done_count", ndone, 1);
        chk("s4_done_after", done_at, NANG);
        go(0, 1, 0, '0, 1);
`ifdef SWEEP_BIDIR_EN
        chk("s4_beam_turn", $signed(beam_angle_out), 20);
`else
        chk("s4_beam_wrap", $signed(beam_angle_out), -30);
`endif

        // Scenario 5: echoes outside listen ignored; echo on final listen cycle wins; enable drops in report.
        do_reset();
        for (int i = 0; i < 1 + S + B; i++) go(0, 1, 1, 16'h0BAD, 1);
        for (int i = 0; i < L - 1; i++) begin
            go(0, 1, 0, '0, 1);
            if (i == 0) chk("s5_listen_start", listen_active_out, 1);
        end
        go(0, 1, 1, 16'h0456, 0);
        chk("s5_listen_last", listen_active_out, 1);
        go(0, 0, 0, '0, 0);
        chk("s5_valid", rpt_valid_out, 1);
        chk("s5_range", rpt_range_out, 16'h0456);
        chk("s5_hit", rpt_hit_out, 1);
        go(0, 0, 0, '0, 1);
        chk("s5_accept", rpt_valid_out, 1);
        go(0, 0, 0, '0, 1);
        chk("s5_adv_busy", busy_out, 1);
        for (int i = 0; i < 4; i++) begin
            go(0, 0, 0, '0, 1);
            chk("s5_idle_busy", busy_out, 0);
            chk("s5_idle_beam", $signed(beam_angle_out), -20);
        end

        // Scenario 6: reset in the middle of a burst.
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            go(0, 1, 0, '0, 1);
            if (tx_active_out) found = 1;
        end
        chk("s6_burst_seen", found, 1);
        go(0, 1, 0, '0, 1);
        go(1, 1, 0, '0, 1);
        chk("s6_still_tx", tx_active_out, 1);
        go(0, 0, 0, '0, 1);
        chk_idle_zero("s6_reset");

`ifdef SWEEP_BIDIR_EN
        do_reset();
        nacc = 0; ndone = 0;
        for (int i = 0; i < 6000 && nacc < 2 * NANG - 1; i++) begin
            go(0, 1, ($urandom_range(0, 15) == 0), RW'($urandom), 1);
            if (sweep_done_out) ndone++;
            if (rpt_valid_out) begin acc_ang[nacc] = $signed(rpt_angle_out); nacc++; end
        end
        go(0, 1, 0, '0, 1);
        if (sweep_done_out) ndone++;
        chk("bidir_records", nacc, 2 * NANG - 1);
        for (int k = 0; k < 2 * NANG - 1; k++)
            chk("bidir_angle", acc_ang[k], ang(k < NANG ? k : 2 * NANG - 2 - k));
        chk("bidir_done_count", ndone, 2);
`endif

        // Random soak: model checks every cycle.
        do_reset();
        en_s = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) en_s = ~en_s;
            go(($urandom_range(0, 799) == 0), en_s, ($urandom_range(0, 19) == 0),
               RW'($urandom), ($urandom_range(0, 1) == 1));
        end
        chk("soak_progress", (m_acc > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
Sequences the sonar ping datapath across a beam-angle sweep. For each steered angle it allows a settle interval, then a transmit burst, then a listen window. It captures the first echo range reported by time_of_flight, or flags a timeout, and hands an {angle, range, hit} record downstream over a valid/ready handshake. It drives beam_angle into sin_lut and replaces the free-running pwm burst timing in top_level.

Parameters:
- ANGLE_WIDTH, 8: signed angle width in degrees.
- ANGLE_MIN, -30: first sweep angle.
- ANGLE_MAX, 30: last sweep angle.
- ANGLE_STEP, 10: increment, >0. The final angle is the last ANGLE_MIN+k*STEP ≤ ANGLE_MAX.
- SETTLE_CYCLES, 16: cycles held after an angle change before the burst, ≥1.
- BURST_CYCLES, 524288: transmit burst length, ≥1.
- LISTEN_CYCLES, 16252928: maximum listen window, ≥1.
- RANGE_WIDTH, 16: echo range width.

Ports:
- clk_in, input, 1: system clock (100 MHz).
- rst_in, input, 1: synchronous, active-high reset.
- enable_in, input, 1: run the sweep while high.
- beam_angle_out, output, ANGLE_WIDTH (signed): current steering angle.
- burst_start_out, output, 1: one-cycle pulse on the first BURST cycle. Used as the datapath reset/restart.
- tx_active_out, output, 1: high for every BURST cycle; gates the transmitters.
- listen_active_out, output, 1: high for every LISTEN cycle; gates the SPI trigger.
- echo_valid_in, input, 1: time_of_flight range valid.
- echo_range_in, input, RANGE_WIDTH: time_of_flight range.
- rpt_valid_out, output, 1: report record valid.
- rpt_ready_in, input, 1: consumer accepts the record.
- rpt_angle_out, output, ANGLE_WIDTH: angle of the record.
- rpt_range_out, output, RANGE_WIDTH: captured range; 0 on timeout.
- rpt_hit_out, output, 1: 1 = echo captured, 0 = timeout.
- sweep_done_out, output, 1: one-cycle pulse when the last-angle record is accepted.
- busy_out, output, 1: high in any state other than IDLE.

Behaviour:
- Reset values:
  - All 1-bit outputs 0.
  - rpt_range_out 0, rpt_angle_out 0.
  - beam_angle_out = ANGLE_MIN.
  - State IDLE, cycle counter 0.
- One shared cycle counter is used, width $clog2(max(SETTLE,BURST,LISTEN)+1). It clears on every state entry.
- States:
  - IDLE: if enable_in is sampled 1, go to SETTLE on the next cycle.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles, then BURST.
  - BURST: lasts exactly BURST_CYCLES cycles. burst_start_out=1 in cycle 0 only; tx_active_out=1 throughout. Then LISTEN.
  - LISTEN: listen_active_out=1.
    - First cycle with echo_valid_in=1: latch echo_range_in, set hit=1, go to REPORT next cycle.
    - Otherwise, after LISTEN_CYCLES cycles: range=0, hit=0, go to REPORT.
    - If an echo and the timeout coincide in the final cycle, the echo wins (hit=1).
  - REPORT: rpt_valid_out=1, with rpt_angle/range/hit stable until a cycle in which rpt_ready_in=1. Acceptance is the cycle with valid&ready; rpt_valid_out drops the next cycle. Then ADVANCE.
  - ADVANCE: one cycle.
    - Not last angle: angle += ANGLE_STEP.
    - Last angle: angle = ANGLE_MIN and sweep_done_out=1 in this cycle.
    - Next state is SETTLE if enable_in=1, else IDLE.
- echo_valid_in is ignored outside LISTEN. Only the first echo per ping is captured.
- enable_in deasserted mid-ping: the current ping, report and handshake complete, then IDLE. The angle is NOT reset, so re-enabling resumes at the next angle.
- The angle-step add is done at ANGLE_WIDTH+1 bits signed to avoid overflow. The last-angle test is angle+STEP > ANGLE_MAX.
- Latencies:
  - enable_in sampled → burst_start_out: SETTLE_CYCLES+1 cycles.
  - echo_valid_in sampled → rpt_valid_out: 1 cycle.
- rst_in in any state returns to reset values on the next edge, aborting any pending report.

Optional Feature:
SWEEP_BIDIR_EN.
- Defined: the sweep ping-pongs. An internal direction bit (reset = up) flips at each endpoint; the endpoint angle is visited once per turn, e.g. -30…30,20…-30,-20…. sweep_done_out pulses at each endpoint acceptance.
- Undefined: sawtooth sweep, wrapping ANGLE_MAX→ANGLE_MIN as above.

Test Plan:
(Overrides for all scenarios: SETTLE=2, BURST=4, LISTEN=20, angles -30..30 step 10.)
1. Reset, then enable_in=1 held, no echoes.
   - burst_start_out pulses 3 cycles after enable is sampled.
   - tx_active_out is high 4 cycles.
   - listen_active_out is high 20 cycles.
   - Record {-30, 0, hit=0}.
2. echo_valid_in in LISTEN cycle 5 with range 0x0123, rpt_ready_in=1.
   - Next cycle: rpt_valid_out=1 with {-30, 0x0123, 1}.
   - A second echo in the same ping is ignored.
   - beam_angle_out becomes -20 after ADVANCE.
3. Backpressure: rpt_ready_in=0 for 10 cycles in REPORT.
   - rpt_* are stable and valid high throughout.
   - Accepted on the first ready cycle; no lost or duplicated record.
4. Full sweep with ready always high.
   - Records at angles -30,-20,…,30.
   - sweep_done_out pulses exactly once, on the 30 acceptance.
   - beam_angle_out returns to -30.
5. echo_valid_in during SETTLE/BURST and at LISTEN cycle 19, coincident with the timeout: only the LISTEN-19 echo is captured, hit=1. Then enable_in drops during REPORT: the record completes, the block goes IDLE, busy_out=0, and the angle holds at the next value.
6. rst_in asserted mid-BURST: the next cycle has all outputs 0, beam_angle_out=-30, state IDLE. With SWEEP_BIDIR_EN: the sequence after 30 is 20, and sweep_done_out pulses at 30 and at -30.
